// File: rtl/morse_if.sv
// Signal bundle between the game side (master) and the Morse controller (slave).
// start, set and strike are single-cycle strobes with no backpressure: a strobe is consumed in the cycle it is high.
interface morse_if;
    logic        start;
    logic        btn_left;
    logic        btn_right;
    logic        btn_tx;
    logic [15:0] data;
    logic        set;
    logic [3:0]  freq_idx;
    logic        solved;
    logic        strike;

    modport master (
        output start, btn_left, btn_right, btn_tx,
        input  data, set, freq_idx, solved, strike
    );

    modport slave (
        input  start, btn_left, btn_right, btn_tx,
        output data, set, freq_idx, solved, strike
    );
endinterface

// File: rtl/morse_ctrl.sv
// Morse module controller: picks a secret word, loads the blinker, debounces the
// tuning/transmit buttons and reports solved or strike.
module morse_ctrl #(
    parameter int         DEB_CYCLES = 50000,
    parameter logic [3:0] LFSR_SEED  = 4'h9
) (
    input  logic       clk,
    input  logic       reset,
    morse_if.slave     bus,
    // FSM state: 0 IDLE, 1 PICK, 2 LOAD, 3 ARMED, 4 CHECK, 5 STRIKE, 6 SOLVED
    output logic [2:0] state_dbg
);
    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PICK   = 3'd1,
        S_LOAD   = 3'd2,
        S_ARMED  = 3'd3,
        S_CHECK  = 3'd4,
        S_STRIKE = 3'd5,
        S_SOLVED = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    lfsr_q, lfsr_d;
    logic [2:0]    word_q, word_d;
    logic [3:0]    freq_q, freq_d;
    logic [2:0]    raw, acc_q, acc_d, prev_q, evt;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [3:0]    target;

    // Button index: 0 left, 1 right, 2 transmit.
    assign raw    = {bus.btn_tx, bus.btn_right, bus.btn_left};
    assign evt    = acc_q & ~prev_q;
    assign lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (raw[i] != acc_q[i]) begin
                if (cnt_q[i] == CNT_LAST) acc_d[i] = raw[i];
                else                      cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        case (word_q)
            3'd1:    target = 4'd2;
            3'd2:    target = 4'd5;
            3'd3:    target = 4'd9;
            3'd4:    target = 4'd13;
            default: target = 4'd0;
        endcase
    end

    always_comb begin
        word_d = word_q;
        freq_d = freq_q;
        if (state_q == S_PICK) word_d = {1'b0, lfsr_q[1:0]} + 3'd1;
        // Transmit swallows any same-cycle tuning; simultaneous left+right cancels.
        if (state_q == S_ARMED && !evt[2] && (evt[0] ^ evt[1])) begin
            if (evt[0] && freq_q != 4'd0)  freq_d = freq_q - 4'd1;
            if (evt[1] && freq_q != 4'd15) freq_d = freq_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_PICK;
            S_PICK:   state_d = S_LOAD;
            S_LOAD:   state_d = S_ARMED;
            S_ARMED:  if (evt[2]) state_d = S_CHECK;
            S_CHECK:  state_d = (freq_q == target) ? S_SOLVED : S_STRIKE;
            S_STRIKE: state_d = S_ARMED;
            S_SOLVED: state_d = S_SOLVED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.data   = '0;
        bus.set    = 1'b0;
        bus.solved = 1'b0;
        bus.strike = 1'b0;
        case (state_q)
            S_LOAD: begin
                bus.data = {13'd0, word_q};
                bus.set  = 1'b1;
            end
            S_ARMED, S_CHECK: bus.data = {13'd0, word_q};
            S_STRIKE: begin
                bus.data   = {13'd0, word_q};
                bus.strike = 1'b1;
            end
            S_SOLVED: bus.solved = 1'b1;
            default: ;
        endcase
    end

    assign bus.freq_idx = freq_q;
    assign state_dbg    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            word_q  <= '0;
            freq_q  <= '0;
            acc_q   <= '0;
            prev_q  <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            word_q  <= word_d;
            freq_q  <= freq_d;
            acc_q   <= acc_d;
            prev_q  <= acc_q;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end
endmodule
